mult_accumulator: RTL and testbench
===================================

# mult_accumulator

Sequential accumulator that sits directly downstream of the team's combinational multiplier and consumes its `2*SIZE`-bit products. It sums a fixed-length run of `LEN` products into a dot-product result and presents that result to the next stage. It uses a valid/ready handshake on both sides and a sticky overflow flag.

## Interface
- `SIZE`, 8, operand width of the upstream multiplier; the product is `2*SIZE` bits.
- `LEN`, 4, number of products summed per run; must be ≥ 1.
- `ACC_W`, 20, accumulator/result width; must be ≥ `2*SIZE`.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a new run.
- `prod`  input  `2*SIZE`  unsigned product from the multiplier.
- `in_valid`  input  1  `prod` is valid this cycle.
- `in_ready`  output  1  block accepts `prod` this cycle.
- `result`  output  `ACC_W`  accumulated sum, modulo 2^`ACC_W`.
- `overflow`  output  1  sticky; set if any addition in the run carried out of `ACC_W` bits.
- `out_valid`  output  1  `result`/`overflow` are valid.
- `out_ready`  input  1  downstream consumes the result.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- **State machine:** IDLE, ACCUM, DONE. Registers: `acc[ACC_W]`, `cnt[clog2(LEN+1)]`, `ovf`.
- **Reset:** state=IDLE, acc=0, cnt=0, ovf=0. All outputs are 0: in_ready, out_valid, busy, result, overflow.
- **IDLE**
  - in_ready=0, out_valid=0.
  - `start`=1 → acc=0, cnt=0, ovf=0, next state ACCUM.
- **ACCUM**
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready. On a transfer: acc ← acc + zero-extended prod, truncated to `ACC_W`; ovf ← ovf | carry-out; cnt ← cnt+1.
  - A transfer with cnt==LEN-1 → next state DONE.
  - `start` is ignored in this state.
- **DONE**
  - in_ready=0, out_valid=1. result=acc and overflow=ovf, held stable until the handshake completes.
  - out_ready=1 and start=0 → IDLE.
  - out_ready=1 and start=1 → clear acc/cnt/ovf, next state ACCUM (back-to-back run).
  - out_ready=0 → remain in DONE; `start` is ignored.
- **Output values outside DONE:** `result` and `overflow` reflect acc/ovf directly. They are meaningful only while out_valid=1.
- **Arithmetic:** unsigned only. The overflow flag never clears within a run.
- **Reset precedence:** reset mid-run (any state) overrides all other inputs. The partial sum is discarded and the next run starts clean.

## Timing
- in_ready is a registered state decode with no combinational path from in_valid.
- out_valid is a registered state decode with no combinational path from out_ready.
- Start to ACCUM: in_ready rises the cycle after `start` is sampled.
- Result latency: out_valid rises one cycle after the LEN-th accepted product.
  - Minimum start→out_valid is LEN+1 cycles, with in_valid held high.
- Throughput: one product per cycle in ACCUM. Bubbles in in_valid stall the count without penalty.
- Minimum run-to-run period with back-to-back start: LEN+1 cycles.
- A product presented while in_ready=0 (IDLE/DONE) is not consumed and has no effect.

## Test plan
- **Reset:** assert reset 2 cycles with random inputs → all outputs 0, busy=0. Release reset with no start → state stays IDLE.
- **Basic run** (defaults): start, then prod=1,2,3,4 on consecutive cycles → out_valid high exactly 5 cycles after start, result=10, overflow=0. out_ready=1 → IDLE next cycle.
- **Bubbles:** prod=100,200,300,400 with in_valid toggling 1,0,1,0… → result=1000. cnt advances only on accepted transfers.
- **Backpressure:** hold out_ready=0 for 6 cycles in DONE while driving in_valid=1, prod=7 and start=1 → result stays stable, in_ready=0, no accumulation, no restart.
- **Overflow** (ACC_W=17): four products of 65025 → result=129028, overflow=1. The next run of 1,1,1,1 → result=4, overflow=0.
- **Reset mid-run, then back-to-back runs:** reset after 2 of 4 products, then a new run of 5,5,5,5 → result=20. In DONE assert out_ready=1 with start=1 and feed 1,1,1,1 → second result=4, out_valid 5 cycles after the handshake.

Source files
------------

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - sums runs of LEN multiplier products with valid/ready on both sides
module mult_accumulator #(
  parameter int SIZE  = 8,
  parameter int LEN   = 4,
  parameter int ACC_W = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2*SIZE-1:0]   prod,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ACC_W-1:0]    result,
  output logic                overflow,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic               xfer;
  logic               clear;
  logic [SUM_W-1:0]   sum;

  // One extra bit on the adder captures the carry that feeds the sticky flag.
  assign sum = {1'b0, acc} + SUM_W'(prod);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer && (cnt == LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = start ? ACCUM : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode only the registered state; clear/xfer are the datapath strobes.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    result    = acc;
    overflow  = ovf;
    xfer      = in_valid && (state == ACCUM);
    clear     = start && ((state == IDLE) || ((state == DONE) && out_ready));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (xfer) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt + CNT_W'(1);
      ovf <= ovf | sum[ACC_W];
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// tb/tb_mult_accumulator.sv - vector table, corner sequences and random runs vs a sum model
module tb_mult_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] prod;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, out_valid, overflow, busy;
  logic [19:0] result;
  logic        in_ready17, out_valid17, overflow17, busy17;
  logic [16:0] result17;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult_accumulator #(.SIZE(8), .LEN(4), .ACC_W(20)) dut (
    .clk(clk), .reset(reset), .start(start), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .overflow(overflow), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  mult_accumulator #(.SIZE(8), .LEN(4), .ACC_W(17)) dut17 (
    .clk(clk), .reset(reset), .start(start), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready17), .result(result17), .overflow(overflow17), .out_valid(out_valid17),
    .out_ready(out_ready), .busy(busy17)
  );

  typedef struct {
    logic [3:0][15:0] p;
    logic [7:0]       bubble;
    logic [19:0]      exp_res;
    logic             exp_ovf;
    logic [16:0]      exp_res17;
    logic             exp_ovf17;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int p0, input int p1, input int p2, input int p3,
                              input int bub, input int r20, input int o20,
                              input int r17, input int o17);
    vec_t v;
    v.p[0] = 16'(p0); v.p[1] = 16'(p1); v.p[2] = 16'(p2); v.p[3] = 16'(p3);
    v.bubble = 8'(bub);
    v.exp_res = 20'(r20); v.exp_ovf = 1'(o20);
    v.exp_res17 = 17'(r17); v.exp_ovf17 = 1'(o17);
    return v;
  endfunction

  // Reference: true sum of the run, reduced mod 2^w; any carry happened iff the true sum reaches 2^w.
  function automatic void model(input logic [3:0][15:0] p, input int w,
                                output logic [31:0] res, output logic ovf);
    longint total = 0;
    longint lim = longint'(1) << w;
    for (int i = 0; i < 4; i++) total += longint'(p[i]);
    res = 32'(total % lim);
    ovf = (total >= lim);
  endfunction

  // Issues start (with whatever out_ready the caller set), feeds four products with bubbles.
  task automatic run(input logic [3:0][15:0] p, input logic [3:0][7:0] bub, output int cyc);
    start = 1'b1;
    in_valid = 1'($urandom % 2);
    prod = 16'($urandom);
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    cyc = 1;
    check("accum_in_ready", 32'(in_ready), 1);
    check("accum_busy", 32'(busy), 1);
    check("clear_on_start", 32'(result), 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      prod = p[i];
      tick();
      cyc++;
      if (i < 3) begin
        check("no_early_valid", 32'(out_valid), 0);
        for (int b = 0; b < int'(bub[i]); b++) begin
          in_valid = 1'b0;
          prod = 16'($urandom);
          tick();
          cyc++;
          check("bubble_no_count", 32'(out_valid), 0);
        end
      end
    end
    in_valid = 1'b0;
    prod = 16'($urandom);
    check("done_out_valid", 32'(out_valid), 1);
    check("done_out_valid17", 32'(out_valid17), 1);
    check("done_in_ready", 32'(in_ready), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [3:0][15:0] p;
    logic [3:0][7:0] bub;
    logic [31:0] er20, er17;
    logic eo20, eo17;
    logic b2b;
    int exp_lat;

    vecs[0] = mk(1, 2, 3, 4, 0, 10, 0, 10, 0);
    vecs[1] = mk(100, 200, 300, 400, 1, 1000, 0, 1000, 0);
    vecs[2] = mk(65025, 65025, 65025, 65025, 0, 260100, 0, 129028, 1);
    vecs[3] = mk(1, 1, 1, 1, 0, 4, 0, 4, 0);
    vecs[4] = mk(65535, 65535, 65535, 65535, 2, 262140, 0, 131068, 1);
    vecs[5] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom % 2); in_valid = 1'($urandom % 2);
      prod = 16'($urandom); out_ready = 1'($urandom % 2);
      tick();
    end
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_result", 32'(result), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_busy17", 32'(busy17), 0);
    check("rst_result17", 32'(result17), 0);

    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom % 2); prod = 16'($urandom); out_ready = 1'($urandom % 2);
      tick();
      check("idle_stays_busy", 32'(busy), 0);
      check("idle_in_ready", 32'(in_ready), 0);
      check("idle_result", 32'(result), 0);
    end

    // Table-driven runs
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      out_ready = 1'b0;
      run(vecs[k].p, {4{vecs[k].bubble}}, cyc);
      check("tbl_result", 32'(result), 32'(vecs[k].exp_res));
      check("tbl_overflow", 32'(overflow), 32'(vecs[k].exp_ovf));
      check("tbl_result17", 32'(result17), 32'(vecs[k].exp_res17));
      check("tbl_overflow17", 32'(overflow17), 32'(vecs[k].exp_ovf17));
      check("tbl_latency", 32'(cyc), 32'(5 + 3 * int'(vecs[k].bubble)));
      out_ready = 1'b1;
      start = 1'b0;
      tick();
      check("tbl_release_busy", 32'(busy), 0);
      check("tbl_release_out_valid", 32'(out_valid), 0);
      out_ready = 1'b0;
    end

    // Backpressure in DONE with distracting inputs
    p = {16'd4, 16'd3, 16'd2, 16'd1};
    run(p, '0, cyc);
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; in_valid = 1'b1; prod = 16'd7; out_ready = 1'b0;
      tick();
      check("bp_result", 32'(result), 10);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_busy", 32'(busy), 0);
    out_ready = 1'b0;

    // Reset mid-run, then a clean run and a back-to-back run
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; prod = 16'd9;
    tick();
    tick();
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_result", 32'(result), 0);
    p = {16'd5, 16'd5, 16'd5, 16'd5};
    run(p, '0, cyc);
    check("midrst_run_result", 32'(result), 20);
    check("midrst_run_overflow", 32'(overflow), 0);
    out_ready = 1'b1;
    p = {16'd1, 16'd1, 16'd1, 16'd1};
    run(p, '0, cyc);
    check("b2b_result", 32'(result), 4);
    check("b2b_latency", 32'(cyc), 5);
    out_ready = 1'b1;
    tick();
    check("b2b_release_busy", 32'(busy), 0);
    out_ready = 1'b0;

    // Random runs against the sum model
    b2b = 1'b0;
    for (int r = 0; r < 40; r++) begin
      exp_lat = 5;
      for (int i = 0; i < 4; i++) begin
        p[i] = (($urandom % 4) == 0) ? 16'(16'hFFFF - ($urandom % 64)) : 16'($urandom);
        bub[i] = (i < 3) ? 8'($urandom_range(0, 2)) : 8'd0;
        exp_lat += int'(bub[i]);
      end
      model(p, 20, er20, eo20);
      model(p, 17, er17, eo17);
      out_ready = b2b;
      run(p, bub, cyc);
      check("rnd_result", 32'(result), er20);
      check("rnd_overflow", 32'(overflow), 32'(eo20));
      check("rnd_result17", 32'(result17), er17);
      check("rnd_overflow17", 32'(overflow17), 32'(eo17));
      check("rnd_latency", 32'(cyc), 32'(exp_lat));
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        out_ready = 1'b0; start = 1'($urandom % 2);
        in_valid = 1'($urandom % 2); prod = 16'($urandom);
        tick();
        check("rnd_hold_result", 32'(result), er20);
        check("rnd_hold_valid", 32'(out_valid), 1);
      end
      b2b = (r < 39) ? 1'($urandom % 2) : 1'b0;
      if (!b2b) begin
        start = 1'b0; out_ready = 1'b1; in_valid = 1'($urandom % 2);
        tick();
        check("rnd_release_busy", 32'(busy), 0);
        out_ready = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
